// File: rtl/keypad_code_entry.sv
// keypad_code_entry: two-digit octal keypad front end for the alarm controller.
// Optional panic key (4'hC) is enabled by defining PANIC_KEY_EN.
`timescale 1ns/1ps
module keypad_code_entry #(
  parameter logic [5:0] ARM_CODE       = 6'o37,
  parameter logic [5:0] DISARM_CODE    = 6'o04,
  parameter logic [5:0] IDLE_CODE      = 6'o00,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         HOLD_CYCLES    = 2,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCKOUT_CYCLES = 5000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           key_valid,
  input  logic [3:0]                     key_code,
  output logic [5:0]                     code,
  output logic                           code_strobe,
  output logic                           entry_err,
  output logic                           locked,
  output logic                           panic,
  output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_DIGIT1  = 3'd1;
  localparam logic [2:0] S_FULL    = 3'd2;
  localparam logic [2:0] S_PRESENT = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  logic [2:0]    state;
  logic [2:0]    d1;
  logic [2:0]    d2;
  logic [TW-1:0] tmo_cnt;
  logic [HW-1:0] hold_cnt;
  logic [LW-1:0] lock_cnt;

  logic       is_digit;
  logic       is_clear;
  logic       is_enter;
  logic       is_panic;
  logic       key_hit;
  logic [2:0] digit;
  logic [5:0] entry;
  logic       code_hit;

  assign is_digit = key_valid && !key_code[3];
  assign is_clear = key_valid && (key_code == 4'hA);
  assign is_enter = key_valid && (key_code == 4'hB);
`ifdef PANIC_KEY_EN
  assign is_panic = key_valid && (key_code == 4'hC);
`else
  assign is_panic = 1'b0;
`endif
  assign key_hit  = is_digit | is_clear | is_enter | is_panic;
  assign digit    = key_code[2:0];
  assign entry    = {d1, d2};
  assign code_hit = (entry == ARM_CODE) || (entry == DISARM_CODE);

  // Entry FSM: digit collection, validation, hold window and lockout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      code        <= IDLE_CODE;
      code_strobe <= 1'b0;
      entry_err   <= 1'b0;
      locked      <= 1'b0;
      panic       <= 1'b0;
      fail_count  <= '0;
      tmo_cnt     <= '0;
      hold_cnt    <= '0;
      lock_cnt    <= '0;
      d1          <= '0;
      d2          <= '0;
    end else begin
      code_strobe <= 1'b0;
      entry_err   <= 1'b0;
      panic       <= 1'b0;
      unique case (state)
        S_IDLE, S_DIGIT1, S_FULL: begin
          if (key_hit) begin
            tmo_cnt <= '0;
          end else if (state != S_IDLE) begin
            if (tmo_cnt == TMO_LAST) begin
              tmo_cnt <= '0;
              d1      <= '0;
              d2      <= '0;
              state   <= S_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + TW'(1);
            end
          end
          unique case (1'b1)
            is_digit: begin
              if (state == S_IDLE) begin
                d1    <= digit;
                state <= S_DIGIT1;
              end else if (state == S_DIGIT1) begin
                d2    <= digit;
                state <= S_FULL;
              end else begin
                d1 <= d2;
                d2 <= digit;
              end
            end
            is_clear, is_panic: begin
              d1    <= '0;
              d2    <= '0;
              panic <= is_panic;
              state <= S_IDLE;
            end
            is_enter: begin
              d1 <= '0;
              d2 <= '0;
              if (state != S_FULL) begin
                state <= S_IDLE;
              end else if (code_hit) begin
                code        <= entry;
                code_strobe <= 1'b1;
                fail_count  <= '0;
                hold_cnt    <= '0;
                state       <= S_PRESENT;
              end else begin
                entry_err  <= 1'b1;
                fail_count <= fail_count + FW'(1);
                if (fail_count == FAIL_LAST) begin
                  locked   <= 1'b1;
                  lock_cnt <= '0;
                  state    <= S_LOCKOUT;
                end else begin
                  state <= S_IDLE;
                end
              end
            end
            default: ;
          endcase
        end
        S_PRESENT: begin
          panic <= is_panic;
          if (hold_cnt == HOLD_LAST) begin
            code     <= IDLE_CODE;
            hold_cnt <= '0;
            state    <= S_IDLE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        S_LOCKOUT: begin
          if (lock_cnt == LOCK_LAST) begin
            locked     <= 1'b0;
            fail_count <= '0;
            lock_cnt   <= '0;
            state      <= S_IDLE;
          end else begin
            lock_cnt <= lock_cnt + LW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_code_entry.sv
// tb_keypad_code_entry: directed keypad sequences checked against a
// behavioural model every cycle, plus literal spot checks.
`timescale 1ns/1ps
module tb_keypad_code_entry;

  localparam int TMO  = 1000;
  localparam int HOLD = 2;
  localparam int MAXF = 3;
  localparam int LOCK = 5000;
`ifdef PANIC_KEY_EN
  localparam bit PANIC_EN = 1'b1;
`else
  localparam bit PANIC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [5:0] code;
  logic       code_strobe;
  logic       entry_err;
  logic       locked;
  logic       panic;
  logic [1:0] fail_count;

  int vecs = 0;
  int misses = 0;
  bit chk_en = 1'b0;

  keypad_code_entry dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .code        (code),
    .code_strobe (code_strobe),
    .entry_err   (entry_err),
    .locked      (locked),
    .panic       (panic),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: pending digits queue and remaining-cycle counters.
  int   digs[$];
  int   idle_run;
  int   present_left;
  int   lock_left;
  int   fails;
  int   m_code;
  bit   m_strobe;
  bit   m_err;
  bit   m_locked;
  bit   m_panic;

  always @(posedge clk) begin
    int k;
    int val;
    bit acc;
    if (rst) begin
      digs.delete();
      idle_run = 0; present_left = 0; lock_left = 0; fails = 0;
      m_code = 0; m_strobe = 0; m_err = 0; m_locked = 0; m_panic = 0;
    end else begin
      k = int'(key_code);
      m_strobe = 0; m_err = 0; m_panic = 0;
      if (present_left > 0) begin
        if (key_valid && k == 12 && PANIC_EN) m_panic = 1;
        present_left--;
        if (present_left == 0) m_code = 0;
      end else if (lock_left > 0) begin
        lock_left--;
        if (lock_left == 0) begin
          m_locked = 0;
          fails = 0;
        end
      end else begin
        acc = key_valid && (k < 8 || k == 10 || k == 11 || (PANIC_EN && k == 12));
        if (acc) begin
          idle_run = 0;
          if (k < 8) begin
            digs.push_back(k);
            if (digs.size() > 2) void'(digs.pop_front());
          end else if (k == 10 || k == 12) begin
            digs.delete();
            m_panic = (k == 12);
          end else begin
            if (digs.size() == 2) begin
              val = digs[0] * 8 + digs[1];
              if (val == 31 || val == 4) begin
                m_code = val;
                m_strobe = 1;
                fails = 0;
                present_left = HOLD;
              end else begin
                m_err = 1;
                fails++;
                if (fails == MAXF) begin
                  lock_left = LOCK;
                  m_locked = 1;
                end
              end
            end
            digs.delete();
          end
        end else if (digs.size() > 0) begin
          idle_run++;
          if (idle_run == TMO) begin
            digs.delete();
            idle_run = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      vecs++;
      if (int'(code) != m_code || code_strobe !== m_strobe ||
          entry_err !== m_err || locked !== m_locked ||
          panic !== m_panic || int'(fail_count) != fails) begin
        misses++;
        $display("FAIL model t=%0t code=%o want %o strobe=%b want %b err=%b want %b locked=%b want %b panic=%b want %b fails=%0d want %0d",
                 $time, code, m_code[5:0], code_strobe, m_strobe, entry_err, m_err,
                 locked, m_locked, panic, m_panic, fail_count, fails);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      misses++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic key(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    lit("async_code", int'(code), 0);
    lit("async_locked", int'(locked), 0);
    lit("async_fails", int'(fail_count), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle(2);
    lit("rst_code", int'(code), 0);
    lit("rst_fails", int'(fail_count), 0);
    lit("rst_locked", int'(locked), 0);
    lit("rst_strobe", int'(code_strobe), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    idle(2);

    key(4'h3); key(4'h7); key(4'hB);
    lit("arm_code", int'(code), 6'o37);
    lit("arm_strobe", int'(code_strobe), 1);
    idle(1);
    lit("arm_hold", int'(code), 6'o37);
    lit("arm_strobe_once", int'(code_strobe), 0);
    idle(1);
    lit("arm_release", int'(code), 0);

    key(4'h0); key(4'h4); key(4'hB);
    lit("disarm_code", int'(code), 6'o04);
    key(4'h3);
    lit("present_ignore", int'(code), 6'o04);
    key(4'h7);
    key(4'hB);
    lit("present_after", int'(code), 0);
    lit("present_no_strobe", int'(code_strobe), 0);

    for (int i = 1; i <= 3; i++) begin
      key(4'h1); key(4'h2); key(4'hB);
      lit("fail_err", int'(entry_err), 1);
      lit("fail_cnt", int'(fail_count), i);
    end
    lit("lock_on", int'(locked), 1);
    key(4'h3); key(4'h7); key(4'hB);
    lit("lock_ignore", int'(code_strobe), 0);
    idle(LOCK - 4);
    lit("lock_last", int'(locked), 1);
    idle(1);
    lit("lock_off", int'(locked), 0);
    lit("lock_clr", int'(fail_count), 0);
    key(4'h3); key(4'h7); key(4'hB);
    lit("post_lock_arm", int'(code), 6'o37);
    idle(3);

    key(4'h5); key(4'h3); key(4'h7); key(4'hB);
    lit("shift_code", int'(code), 6'o37);
    idle(3);
    key(4'h3); key(4'hA); key(4'h7); key(4'hB);
    lit("clear_strobe", int'(code_strobe), 0);
    lit("clear_err", int'(entry_err), 0);

    key(4'h1); key(4'h2); key(4'hB);
    lit("pre_tmo_fail", int'(fail_count), 1);
    key(4'h3); idle(TMO); key(4'h7); key(4'hB);
    lit("tmo_strobe", int'(code_strobe), 0);
    lit("tmo_err", int'(entry_err), 0);
    lit("tmo_fails", int'(fail_count), 1);
    key(4'h3); idle(TMO - 1); key(4'h7); key(4'hB);
    lit("tmo_edge_code", int'(code), 6'o37);
    lit("tmo_edge_fails", int'(fail_count), 0);
    idle(3);

`ifdef PANIC_KEY_EN
    key(4'h3); key(4'hC);
    lit("panic_pulse", int'(panic), 1);
    key(4'h7); key(4'hB);
    lit("panic_no_strobe", int'(code_strobe), 0);
    key(4'h0); key(4'h4); key(4'hB);
    key(4'hC);
    lit("panic_present", int'(panic), 1);
    lit("panic_hold", int'(code), 6'o04);
    idle(3);
`else
    key(4'h3); key(4'hC);
    lit("panic_off", int'(panic), 0);
    key(4'h7); key(4'hB);
    lit("panic_ign_code", int'(code), 6'o37);
    lit("panic_ign_strobe", int'(code_strobe), 1);
    idle(3);
`endif

    key(4'h0); key(4'h4); key(4'hB);
    async_reset();
    for (int i = 0; i < 3; i++) begin
      key(4'h6); key(4'h6); key(4'hB);
    end
    lit("pre_rst_locked", int'(locked), 1);
    async_reset();
    idle(3);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
    $finish;
  end

endmodule
